// File: rtl/aurora_tx_arbiter_if.sv
// Packer request streams plus the shared Aurora TX AXI4-Stream channel.
interface aurora_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64
);
    logic [NUM_REQ*DATA_W-1:0] req_tdata;
    logic [NUM_REQ-1:0]        req_tvalid;
    logic [NUM_REQ-1:0]        req_tlast;
    logic [NUM_REQ-1:0]        req_tready;
    logic [DATA_W-1:0]         s_axi_tx_tdata;
    logic                      s_axi_tx_tvalid;
    logic                      s_axi_tx_tlast;
    logic                      s_axi_tx_tready;

    // master: the arbiter, which drives the Aurora stream and the packer readies
    modport master (
        input  req_tdata, req_tvalid, req_tlast, s_axi_tx_tready,
        output req_tready, s_axi_tx_tdata, s_axi_tx_tvalid, s_axi_tx_tlast
    );

    modport slave (
        output req_tdata, req_tvalid, req_tlast, s_axi_tx_tready,
        input  req_tready, s_axi_tx_tdata, s_axi_tx_tvalid, s_axi_tx_tlast
    );
endinterface

// File: rtl/aurora_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one Aurora TX stream among NUM_REQ packers,
// with a per-frame beat limit that truncates and drains runaway packets.
module aurora_tx_arbiter #(
    parameter int  NUM_REQ         = 4,
    parameter int  NUMBER_OF_LANES = 2,
    parameter int  MAX_BEATS       = 16,
    localparam int DATA_W          = 32 * NUMBER_OF_LANES,
    localparam int GW              = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      user_clk,
    input  logic                      reset_TX_RX_Block,
    aurora_tx_arbiter_if.master       bus,
    input  logic                      err_clear,
    output logic [GW-1:0]             grant_id,
    output logic                      busy,
    output logic [NUM_REQ-1:0]        overlength_err
);
    localparam int            CW       = $clog2(MAX_BEATS) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;

    state_e             state_q, state_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [GW-1:0]      last_grant_q, last_grant_d;
    logic [CW-1:0]      beat_cnt_q, beat_cnt_d;
    logic               busy_q, busy_d;

    logic [GW-1:0]      rr_idx;
    logic [GW-1:0]      pick;
    logic               any_vld;
    logic               g_vld, g_last, at_limit, accept;
    logic [DATA_W-1:0]  g_data;
    logic [NUM_REQ-1:0] err_set;

    // Walk downward so the nearest requester above last_grant overrides farther ones.
    always_comb begin
        rr_idx  = '0;
        pick    = last_grant_q;
        any_vld = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            rr_idx = GW'((int'(last_grant_q) + k) % NUM_REQ);
            if (bus.req_tvalid[rr_idx]) begin
                pick    = rr_idx;
                any_vld = 1'b1;
            end
        end
    end

    always_comb begin
        g_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GW'(i)) g_data = bus.req_tdata[i*DATA_W +: DATA_W];
        end
    end

    assign g_vld    = bus.req_tvalid[grant_q];
    assign g_last   = bus.req_tlast[grant_q];
    assign at_limit = (beat_cnt_q == LAST_CNT);
    assign accept   = (state_q == BUSY) && g_vld && bus.s_axi_tx_tready;

    always_ff @(posedge user_clk) begin
        if (reset_TX_RX_Block) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        err_set      = '0;
        unique case (state_q)
            IDLE: begin
                if (any_vld) begin
                    state_d      = BUSY;
                    grant_d      = pick;
                    last_grant_d = pick;
                    beat_cnt_d   = '0;
                end
            end
            BUSY: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (g_last) begin
                        state_d = IDLE;
                    end else if (at_limit) begin
                        state_d          = DRAIN;
                        err_set[grant_q] = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (g_vld && g_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Data path is gated by state, so nothing reaches Aurora outside BUSY.
    always_comb begin
        bus.s_axi_tx_tdata  = '0;
        bus.s_axi_tx_tvalid = 1'b0;
        bus.s_axi_tx_tlast  = 1'b0;
        bus.req_tready      = '0;
        case (state_q)
            BUSY: begin
                bus.s_axi_tx_tdata      = g_data;
                bus.s_axi_tx_tvalid     = g_vld;
                bus.s_axi_tx_tlast      = g_last | at_limit;
                bus.req_tready[grant_q] = bus.s_axi_tx_tready;
            end
            DRAIN: bus.req_tready[grant_q] = 1'b1;
            default: ;
        endcase
    end

    // Sticky per-requester length violation; a new set beats a simultaneous clear.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_err
        logic err_q, err_d;
        always_comb err_d = err_set[i] | (err_q & ~err_clear);
        always_ff @(posedge user_clk) begin
            if (reset_TX_RX_Block) err_q <= 1'b0;
            else                   err_q <= err_d;
        end
        assign overlength_err[i] = err_q;
    end

    assign grant_id = grant_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Scoreboarded bench: packets are modelled per requester, a monitor checks every beat Aurora accepts.
module tb_aurora_tx_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int LANES     = 2;
    localparam int MAX_BEATS = 16;
    localparam int DATA_W    = 32 * LANES;

    typedef struct {
        logic [DATA_W-1:0] data;
        bit                last;
        bit                ovl;
    } beat_t;

    logic               user_clk = 1'b0;
    logic               reset_TX_RX_Block;
    logic               err_clear;
    logic [1:0]         grant_id;
    logic               busy;
    logic [NUM_REQ-1:0] overlength_err;

    aurora_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    aurora_tx_arbiter #(.NUM_REQ(NUM_REQ), .NUMBER_OF_LANES(LANES), .MAX_BEATS(MAX_BEATS)) dut (
        .user_clk          (user_clk),
        .reset_TX_RX_Block (reset_TX_RX_Block),
        .bus               (bus),
        .err_clear         (err_clear),
        .grant_id          (grant_id),
        .busy              (busy),
        .overlength_err    (overlength_err)
    );

    always #5 user_clk = ~user_clk;

    beat_t              stim_q [NUM_REQ][$];
    beat_t              exp_q  [NUM_REQ][$];
    logic [NUM_REQ-1:0] exp_err;
    int                 seq_cnt [NUM_REQ];
    int                 start_r[$];
    int                 start_cyc[$];
    int                 end_cyc[$];
    int                 cyc = 0;
    int                 gap_pct = 0;
    bit                 rdy_mode = 1'b1;
    bit                 rdy_val = 1'b1;
    int                 n_cmp = 0;
    int                 n_bad = 0;

    always @(posedge user_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected output: first MAX_BEATS beats, the last of them carrying tlast.
    task automatic add_pkt(input int r, input int len);
        logic [23:0] salt;
        beat_t       b;
        salt = 24'($urandom);
        seq_cnt[r]++;
        for (int i = 0; i < len; i++) begin
            b.data = {8'(r), 16'(seq_cnt[r]), 16'(i), salt};
            b.last = (i == len - 1);
            b.ovl  = 1'b0;
            stim_q[r].push_back(b);
            if (i < MAX_BEATS) begin
                b.last = (i == len - 1) || (i == MAX_BEATS - 1);
                b.ovl  = (i == MAX_BEATS - 1) && (len > MAX_BEATS);
                exp_q[r].push_back(b);
            end
        end
        if (len > MAX_BEATS) exp_err[r] = 1'b1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int t;
        bit done;
        t = 0;
        done = 1'b0;
        while (!done && t < budget) begin
            @(negedge user_clk);
            t++;
            done = !busy;
            for (int r = 0; r < NUM_REQ; r++)
                if (stim_q[r].size() != 0 || exp_q[r].size() != 0) done = 1'b0;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s_drain: traffic still pending after %0d cycles", name, budget);
        end
        chk({name, "_err_flags"}, 64'(overlength_err), 64'(exp_err));
    endtask

    // Returns at the negedge where requester tag presents beat index bt.
    task automatic wait_beat(input int tag, input int bt, input bit need_rdy, input string name);
        int t;
        bit hit;
        t = 0;
        hit = 1'b0;
        while (!hit && t < 300) begin
            @(negedge user_clk);
            t++;
            hit = bus.s_axi_tx_tvalid && (bus.s_axi_tx_tready || !need_rdy) &&
                  (int'(bus.s_axi_tx_tdata[63:56]) == tag) && (int'(bus.s_axi_tx_tdata[39:24]) == bt);
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL %s_wait: beat %0d of req %0d never presented", name, bt, tag);
        end
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_busy"},   64'(busy), 0);
        chk({name, "_grant"},  64'(grant_id), 0);
        chk({name, "_err"},    64'(overlength_err), 0);
        chk({name, "_tvalid"}, 64'(bus.s_axi_tx_tvalid), 0);
        chk({name, "_tlast"},  64'(bus.s_axi_tx_tlast), 0);
        chk({name, "_tdata"},  bus.s_axi_tx_tdata, 0);
        chk({name, "_rdy"},    64'(bus.req_tready), 0);
    endtask

    // Requester packers and Aurora tready: update half a cycle after the sampled handshake.
    initial begin : drv
        bit fire [NUM_REQ];
        bus.req_tvalid      = '0;
        bus.req_tlast       = '0;
        bus.req_tdata       = '0;
        bus.s_axi_tx_tready = 1'b0;
        forever begin
            @(negedge user_clk);
            for (int r = 0; r < NUM_REQ; r++) fire[r] = bus.req_tvalid[r] && bus.req_tready[r];
            @(posedge user_clk);
            #1;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (fire[r] && stim_q[r].size() > 0) void'(stim_q[r].pop_front());
                if (stim_q[r].size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
                    bus.req_tvalid[r]                 = 1'b1;
                    bus.req_tlast[r]                  = stim_q[r][0].last;
                    bus.req_tdata[r*DATA_W +: DATA_W] = stim_q[r][0].data;
                end else begin
                    bus.req_tvalid[r]                 = 1'b0;
                    bus.req_tlast[r]                  = 1'($urandom_range(1));
                    bus.req_tdata[r*DATA_W +: DATA_W] = {$urandom, $urandom};
                end
            end
            bus.s_axi_tx_tready = rdy_mode ? rdy_val : ($urandom_range(99) < 70);
        end
    end

    initial begin : mon
        bit    in_frame;
        bit    idle_next;
        int    r;
        beat_t e;
        in_frame  = 1'b0;
        idle_next = 1'b0;
        forever begin
            @(negedge user_clk);
            if (reset_TX_RX_Block) begin
                in_frame  = 1'b0;
                idle_next = 1'b0;
            end else begin
                if (idle_next) begin
                    chk("gap_busy", 64'(busy), 0);
                    chk("gap_tvalid", 64'(bus.s_axi_tx_tvalid), 0);
                    idle_next = 1'b0;
                end
                if (!busy) begin
                    chk("idle_tvalid", 64'(bus.s_axi_tx_tvalid), 0);
                    chk("idle_tdata", bus.s_axi_tx_tdata, 0);
                    chk("idle_rdy", 64'(bus.req_tready), 0);
                end
                if (bus.s_axi_tx_tvalid && bus.s_axi_tx_tready) begin
                    r = int'(bus.s_axi_tx_tdata[63:56]);
                    if (r >= NUM_REQ || exp_q[r].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL stray_beat: got %0h expected no beat (cycle %0d)", bus.s_axi_tx_tdata, cyc);
                    end else begin
                        e = exp_q[r].pop_front();
                        chk("beat_data", bus.s_axi_tx_tdata, e.data);
                        chk("beat_tlast", 64'(bus.s_axi_tx_tlast), 64'(e.last));
                        chk("beat_grant", 64'(grant_id), 64'(r));
                        if (!in_frame) begin
                            start_r.push_back(r);
                            start_cyc.push_back(cyc);
                            in_frame = 1'b1;
                        end
                        if (e.last) begin
                            in_frame = 1'b0;
                            end_cyc.push_back(cyc);
                            if (!e.ovl) idle_next = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin : main
        int ns, ne, t, r, len;
        exp_err           = '0;
        err_clear         = 1'b0;
        reset_TX_RX_Block = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) seq_cnt[i] = 0;
        repeat (3) @(posedge user_clk);
        @(negedge user_clk);
        chk_reset("por");
        reset_TX_RX_Block = 1'b0;

        // Round robin: all four contend, requester 0 has a second packet queued.
        ns = start_r.size();
        ne = end_cyc.size();
        for (int i = 0; i < NUM_REQ; i++) add_pkt(i, 16);
        add_pkt(0, 16);
        wait_idle(400, "rr");
        chk("rr_frames", 64'(start_r.size() - ns), 5);
        if (start_r.size() - ns == 5 && end_cyc.size() - ne == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("rr_order", 64'(start_r[ns+i]), 64'(i % NUM_REQ));
                chk("rr_len", 64'(end_cyc[ne+i] - start_cyc[ns+i] + 1), 16);
            end
            for (int i = 0; i < 4; i++) chk("rr_gap", 64'(start_cyc[ns+i+1] - end_cyc[ne+i]), 2);
        end

        // Single requester: arbitration latency of one cycle.
        add_pkt(1, 16);
        t = 0;
        while (!bus.req_tvalid[1] && t < 20) begin
            @(negedge user_clk);
            t++;
        end
        chk("lat_req_valid", 64'(bus.req_tvalid[1]), 1);
        chk("lat_busy_n", 64'(busy), 0);
        @(negedge user_clk);
        chk("lat_busy_n1", 64'(busy), 1);
        chk("lat_grant_n1", 64'(grant_id), 1);
        chk("lat_tvalid_n1", 64'(bus.s_axi_tx_tvalid), 1);
        wait_idle(100, "single");

        // Backpressure: Aurora stalls 5 cycles with beat 7 on the bus.
        add_pkt(1, 16);
        wait_beat(1, 6, 1'b1, "bp");
        rdy_val = 1'b0;
        repeat (5) begin
            @(negedge user_clk);
            chk("bp_hold_beat", 64'(bus.s_axi_tx_tdata[39:24]), 7);
            chk("bp_tvalid", 64'(bus.s_axi_tx_tvalid), 1);
            chk("bp_req_rdy", 64'(bus.req_tready), 0);
        end
        rdy_val = 1'b1;
        wait_idle(100, "bp");

        // Overlength: 20-beat packet truncated at 16, tail drained.
        add_pkt(2, 20);
        wait_idle(100, "ovl");
        chk("ovl_flag", 64'(overlength_err), 64'(4'b0100));

        // Reset mid-frame at beat 7 of requester 3.
        add_pkt(3, 16);
        wait_beat(3, 7, 1'b0, "rst");
        reset_TX_RX_Block = 1'b1;
        @(negedge user_clk);
        chk_reset("midrst");
        for (int i = 0; i < NUM_REQ; i++) begin
            stim_q[i].delete();
            exp_q[i].delete();
        end
        exp_err = '0;
        @(negedge user_clk);
        reset_TX_RX_Block = 1'b0;
        ns = start_r.size();
        for (int i = 0; i < NUM_REQ; i++) add_pkt(i, int'($urandom_range(16, 1)));
        t = 0;
        while (start_r.size() == ns && t < 20) begin
            @(negedge user_clk);
            t++;
        end
        chk("rst_frame_seen", 64'(start_r.size() > ns), 1);
        if (start_r.size() > ns) chk("rst_next_grant", 64'(start_r[ns]), 0);
        wait_idle(300, "postrst");

        // Clear racing with a new overlength: the set must survive.
        add_pkt(0, 20);
        wait_beat(0, 15, 1'b1, "race");
        err_clear = 1'b1;
        exp_err   = 4'b0001;
        @(negedge user_clk);
        err_clear = 1'b0;
        chk("race_err", 64'(overlength_err), 64'(exp_err));
        wait_idle(100, "race");
        err_clear = 1'b1;
        @(negedge user_clk);
        err_clear = 1'b0;
        exp_err   = '0;
        chk("clear_err", 64'(overlength_err), 64'(exp_err));

        // Random traffic: random lengths, valid gaps and Aurora backpressure.
        gap_pct  = 20;
        rdy_mode = 1'b0;
        for (int c = 0; c < 800; c++) begin
            @(negedge user_clk);
            if ($urandom_range(99) < 12) begin
                r = int'($urandom_range(NUM_REQ - 1));
                len = ($urandom_range(99) < 15) ? int'($urandom_range(24, 17)) : int'($urandom_range(16, 1));
                if (stim_q[r].size() < 40) add_pkt(r, len);
            end
        end
        wait_idle(6000, "rand");
        rdy_mode = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
